// File: rtl/single_port_ram_be.sv
// Word-wide single-port RAM with byte enables, read handshake and post-reset clear.
// Optional per-byte even parity storage enabled by defining RAM_PARITY_EN.
module single_port_ram_be #(
    parameter  int ADDR_WIDTH     = 14,
    parameter  int DATA_WIDTH     = 32,
    parameter  int CLEAR_ON_RESET = 1,
    localparam int NUM_BYTES      = DATA_WIDTH / 8,
    localparam int DEPTH          = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [NUM_BYTES-1:0]  byte_en,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic                  inject_parity_err,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  parity_err
);

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_valid;
    logic                  r_parity_err;
    logic [NUM_BYTES-1:0]  w_par_mis;
    logic                  w_clr;
    logic                  w_wr;
    logic                  w_rd;

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_CLEAR && (&r_clr_cnt))
            w_state_nxt = S_READY;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == S_READY);
            if (r_state == S_CLEAR)
                r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    // Clear writes must not fire while reset is still held.
    assign w_clr = (r_state == S_CLEAR) && !reset;
    assign w_wr  = r_ready && write_en;
    assign w_rd  = r_ready && read_en;

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr) begin
            for (int i = 0; i < NUM_BYTES; i++)
                if (byte_en[i])
                    r_mem[addr][8*i +: 8] <= din[8*i +: 8];
        end
    end

`ifdef RAM_PARITY_EN
    logic [NUM_BYTES-1:0] r_par [DEPTH];

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_par[r_clr_cnt] <= '0;
        end else if (w_wr) begin
            for (int i = 0; i < NUM_BYTES; i++)
                if (byte_en[i])
                    r_par[addr][i] <= (^din[8*i +: 8]) ^ inject_parity_err;
        end
    end

    always_comb begin
        w_par_mis = '0;
        for (int i = 0; i < NUM_BYTES; i++)
            w_par_mis[i] = (^r_mem[addr][8*i +: 8]) ^ r_par[addr][i];
    end
`else
    logic w_unused_inj;
    assign w_unused_inj = inject_parity_err;
    assign w_par_mis    = '0;
`endif

    // Read-first: the array write above lands after this sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_dout_valid <= w_rd;
            r_parity_err <= w_rd && (|w_par_mis);
            if (w_rd)
                r_dout <= r_mem[addr];
        end
    end

    assign ready      = r_ready;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign parity_err = r_parity_err;

endmodule

// File: tb/tb_single_port_ram_be.sv
// Directed bench for single_port_ram_be (ADDR_WIDTH=4, DATA_WIDTH=32, clear on reset).
// Parity expectations follow RAM_PARITY_EN when the bench is built with it.
module tb_single_port_ram_be;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  addr;
    logic [31:0] din;
    logic [3:0]  byte_en;
    logic        write_en;
    logic        read_en;
    logic        inject_parity_err;
    logic        ready;
    logic [31:0] dout;
    logic        dout_valid;
    logic        parity_err;

    int n_checks = 0;
    int n_err    = 0;

    single_port_ram_be #(
        .ADDR_WIDTH     (4),
        .DATA_WIDTH     (32),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .addr              (addr),
        .din               (din),
        .byte_en           (byte_en),
        .write_en          (write_en),
        .read_en           (read_en),
        .inject_parity_err (inject_parity_err),
        .ready             (ready),
        .dout              (dout),
        .dout_valid        (dout_valid),
        .parity_err        (parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [3:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
        logic        ev;
        logic [31:0] ed;
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];

`ifdef RAM_PARITY_EN
    localparam logic EXP_INJ = 1'b1;
`else
    localparam logic EXP_INJ = 1'b0;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reset has just been released: expect 16 cycles of ready=0 then ready=1.
    task automatic do_clear(input string tag);
        chk({tag, " ready c1"}, 32'(ready), 32'd0);
        chk({tag, " dv c1"}, 32'(dout_valid), 32'd0);
        for (int c = 2; c <= 16; c++) begin
            step();
            chk($sformatf("%s ready c%0d", tag, c), 32'(ready), 32'd0);
            chk($sformatf("%s dv c%0d", tag, c), 32'(dout_valid), 32'd0);
        end
        step();
        chk({tag, " ready c17"}, 32'(ready), 32'd1);
        chk({tag, " dv c17"}, 32'(dout_valid), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{1'b1, 1'b0, 4'd5, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
        vt[1]  = '{1'b1, 1'b0, 4'd5, 32'h11223344, 4'h5, 1'b0, 32'h0};
        vt[2]  = '{1'b0, 1'b1, 4'd5, 32'h0,        4'h0, 1'b1, 32'hDE22BE44};
        vt[3]  = '{1'b1, 1'b1, 4'd7, 32'hCAFEF00D, 4'hF, 1'b1, 32'h0};
        vt[4]  = '{1'b0, 1'b1, 4'd7, 32'h0,        4'h0, 1'b1, 32'hCAFEF00D};
        vt[5]  = '{1'b1, 1'b0, 4'd1, 32'hA,        4'hF, 1'b0, 32'hCAFEF00D};
        vt[6]  = '{1'b1, 1'b0, 4'd2, 32'hB,        4'hF, 1'b0, 32'hCAFEF00D};
        vt[7]  = '{1'b1, 1'b0, 4'd3, 32'hC,        4'hF, 1'b0, 32'hCAFEF00D};
        vt[8]  = '{1'b0, 1'b1, 4'd1, 32'h0,        4'h0, 1'b1, 32'hA};
        vt[9]  = '{1'b0, 1'b1, 4'd2, 32'h0,        4'h0, 1'b1, 32'hB};
        vt[10] = '{1'b0, 1'b1, 4'd3, 32'h0,        4'h0, 1'b1, 32'hC};
        vt[11] = '{1'b0, 1'b0, 4'd3, 32'h0,        4'h0, 1'b0, 32'hC};
        vt[12] = '{1'b1, 1'b0, 4'd5, 32'hFFFFFFFF, 4'h0, 1'b0, 32'hC};
        vt[13] = '{1'b0, 1'b1, 4'd5, 32'h0,        4'h0, 1'b1, 32'hDE22BE44};
        vt[14] = '{1'b1, 1'b0, 4'd4, 32'h12345678, 4'hF, 1'b0, 32'hDE22BE44};
        vt[15] = '{1'b0, 1'b1, 4'd4, 32'h0,        4'h0, 1'b1, 32'h12345678};

        reset = 1'b1;
        addr = 4'd3;
        din = '0;
        byte_en = '0;
        write_en = 1'b0;
        read_en = 1'b1;
        inject_parity_err = 1'b0;
        #1;
        chk("rst ready", 32'(ready), 32'd0);
        chk("rst dout", dout, 32'h0);
        chk("rst dv", 32'(dout_valid), 32'd0);
        chk("rst perr", 32'(parity_err), 32'd0);
        step();
        step();
        reset = 1'b0;

        do_clear("clr1");
        step();
        chk("first rd dv", 32'(dout_valid), 32'd1);
        chk("first rd dout", dout, 32'h0);
        read_en = 1'b0;

        for (int i = 0; i < NV; i++) begin
            write_en = vt[i].we;
            read_en  = vt[i].re;
            addr     = vt[i].a;
            din      = vt[i].d;
            byte_en  = vt[i].be;
            step();
            chk($sformatf("vec%0d dv", i), 32'(dout_valid), 32'(vt[i].ev));
            chk($sformatf("vec%0d dout", i), dout, vt[i].ed);
            chk($sformatf("vec%0d perr", i), 32'(parity_err), 32'd0);
        end
        write_en = 1'b0;
        read_en  = 1'b0;
        byte_en  = '0;

        reset = 1'b1;
        #1;
        chk("async rst ready", 32'(ready), 32'd0);
        chk("async rst dout", dout, 32'h0);
        step();
        reset = 1'b0;
        repeat (8) step();
        chk("mid clr ready", 32'(ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("mid clr rst ready", 32'(ready), 32'd0);
        step();
        write_en = 1'b1;
        addr     = 4'd4;
        din      = 32'hFFFFFFFF;
        byte_en  = 4'hF;
        reset    = 1'b0;
        do_clear("clr2");
        write_en = 1'b0;
        read_en  = 1'b1;
        step();
        chk("post clr rd dv", 32'(dout_valid), 32'd1);
        chk("post clr rd dout", dout, 32'h0);

        reset = 1'b1;
        #1;
        chk("mid rd rst dv", 32'(dout_valid), 32'd0);
        chk("mid rd rst dout", dout, 32'h0);
        read_en = 1'b0;
        step();
        reset = 1'b0;
        do_clear("clr3");

        write_en = 1'b1;
        addr = 4'd9;
        din = 32'h000000FF;
        byte_en = 4'hF;
        inject_parity_err = 1'b1;
        step();
        write_en = 1'b0;
        inject_parity_err = 1'b0;
        read_en = 1'b1;
        step();
        chk("par rd9 dv", 32'(dout_valid), 32'd1);
        chk("par rd9 dout", dout, 32'h000000FF);
        chk("par rd9 perr", 32'(parity_err), 32'(EXP_INJ));
        addr = 4'd2;
        step();
        chk("par rd2 dv", 32'(dout_valid), 32'd1);
        chk("par rd2 dout", dout, 32'h0);
        chk("par rd2 perr", 32'(parity_err), 32'd0);
        read_en = 1'b0;
        step();
        chk("par idle dv", 32'(dout_valid), 32'd0);
        chk("par idle perr", 32'(parity_err), 32'd0);
        chk("par idle dout", dout, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/single_port_ram_be.md
Name: single_port_ram_be

Overview:
- Next-generation on-chip single-port RAM for the MCU memory subsystem. It replaces the per-byte 8-bit RAM instances with one word-wide RAM.
- Word width is parametrised, with per-byte write enables.
- Has an explicit read-request/read-valid handshake and a post-reset hardware clear sequencer.
- Sits between the memory arbiter (instruction/data bus) and the physical block RAM.

Parameters:
- ADDR_WIDTH, 14, word address width; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8; NUM_BYTES = DATA_WIDTH/8.
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset before accepting requests; 0 = ready immediately.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-high reset.
- addr  input  ADDR_WIDTH  word address of the request.
- din  input  DATA_WIDTH  write data.
- byte_en  input  NUM_BYTES  per-byte write enable; bit i covers din[8i+7:8i].
- write_en  input  1  write request, qualified by byte_en.
- read_en  input  1  read request.
- inject_parity_err  input  1  test hook; only active with RAM_PARITY_EN.
- ready  output  1  high when requests are accepted.
- dout  output  DATA_WIDTH  registered read data.
- dout_valid  output  1  one-cycle pulse marking new dout.
- parity_err  output  1  read parity mismatch, aligned with dout_valid.

Behaviour:
- Reset (async assert) values: ready=0, dout=0, dout_valid=0, parity_err=0, clear counter=0, FSM=S_CLEAR (CLEAR_ON_RESET=1) or S_READY (CLEAR_ON_RESET=0).
- Array contents are not reset by the reset signal itself.
- FSM states:
  - S_CLEAR: every cycle writes all-zero data (and parity bits 0) to word clr_cnt, then clr_cnt increments. On clr_cnt == 2**ADDR_WIDTH-1 the FSM moves to S_READY. Clear takes exactly 2**ADDR_WIDTH cycles after reset deasserts.
  - S_READY: ready=1; stays there until reset.
- ready is registered: first cycle with ready=1 is the cycle after the last clear write.
- While ready=0, write_en and read_en are ignored: no array change, no dout_valid.
- Write (ready=1, write_en=1): at the clock edge, byte lanes with byte_en[i]=1 take din; other lanes are unchanged. byte_en=0 with write_en=1 leaves the word unchanged.
- Read (ready=1, read_en=1) has 1-cycle latency.
  - dout is updated at the next edge and dout_valid=1 for exactly that cycle.
  - dout holds its last value while no read completes.
  - Back-to-back reads each produce a dout_valid pulse.
- Read and write to the same address in the same cycle: read-first. dout returns the pre-write word; the write still takes effect.
- Reset mid-clear: restarts the clear at word 0, ready drops immediately.
- Reset mid-read: the pending dout_valid is dropped.
- Address is taken modulo depth; no out-of-range behaviour exists.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - Array stores one even-parity bit per byte lane, written with that lane.
  - If inject_parity_err=1 during a write, the stored parity bit of each enabled lane is inverted.
  - On read, parity is recomputed per lane. parity_err = OR of lane mismatches, registered and asserted only with dout_valid.
  - Clear writes parity 0.
- Undefined: no parity storage, inject_parity_err ignored, parity_err tied 0.
- Port list is identical in both builds.

Test Plan (bench: ADDR_WIDTH=4, DATA_WIDTH=32, CLEAR_ON_RESET=1):
1. Release reset; hold read_en=1, addr=3 throughout -> ready=0 and no dout_valid for 16 cycles. ready=1 on cycle 17. Then read of addr 3 returns dout=0x00000000 with dout_valid pulse one cycle after the request.
2. Write addr 5 din=0xDEADBEEF byte_en=4'b1111, then addr 5 din=0x11223344 byte_en=4'b0101. Read addr 5 -> dout=0xDE22BE44.
3. Same cycle write addr 7 din=0xCAFEF00D byte_en=4'hF with read_en addr 7 (old value 0) -> dout=0x00000000. Next read of addr 7 -> dout=0xCAFEF00D.
4. Assert reset at clear cycle 8, release it -> ready stays 0 for a further 16 cycles. A word previously written to 0x12345678 reads 0 afterward.
5. Reads of addrs 1, 2, 3 on consecutive cycles (preloaded 0xA, 0xB, 0xC) -> three consecutive dout_valid cycles with dout 0xA, 0xB, 0xC. dout holds 0xC afterward with dout_valid=0.
6. RAM_PARITY_EN build: write addr 9 din=0x000000FF with inject_parity_err=1, then read addr 9 -> dout=0x000000FF, parity_err=1 with dout_valid. A read of addr 2 gives parity_err=0.
